// File: rtl/vdma_pkg.sv
// Shared VDMA frame-store definitions: pointer width, reset slots and the
// one-hot rotate used by both write and read base loops.
package vdma_pkg;

    localparam int PTR_W = 5;
    localparam logic [PTR_W-1:0] WR_PTR_RST = 5'b00001;
    localparam logic [PTR_W-1:0] RD_PTR_RST = 5'b00010;

    // Rotate a one-hot slot left, wrapping at bit n-1 instead of PTR_W-1.
    function automatic logic [PTR_W-1:0] rotl_onehot(input logic [PTR_W-1:0] p,
                                                      input int n);
        logic [PTR_W-1:0] r;
        r = '0;
        for (int i = 0; i < PTR_W; i++) begin
            if (i < n) begin
                if (i == n - 1)
                    r[0] = r[0] | p[i];
                else
                    r[(i + 1) % PTR_W] = p[i];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/ptr_sync.sv
// Brings the reader's one-hot slot into the write clock domain and only
// accepts it once it has been stable and legal for a full compare cycle.
module ptr_sync
    import vdma_pkg::*;
#(
    parameter int BUF_NUM = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PTR_W-1:0] d,
    output logic [PTR_W-1:0] q
);

    localparam logic [PTR_W-1:0] SLOT_MASK = PTR_W'((1 << BUF_NUM) - 1);

    logic [PTR_W-1:0] s1;
    logic [PTR_W-1:0] s2;
    logic [PTR_W-1:0] s3;
    logic             accept;

    // A multi-bit bus can be caught mid-transition; equality across two
    // stages plus a legality check filters out torn samples.
    assign accept = (s2 == s3) && $onehot(s2) && ((s2 & ~SLOT_MASK) == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= RD_PTR_RST;
            s2 <= RD_PTR_RST;
            s3 <= RD_PTR_RST;
            q  <= RD_PTR_RST;
        end else begin
            s1 <= d;
            s2 <= s1;
            s3 <= s2;
            if (accept)
                q <= s2;
        end
    end

endmodule

// File: rtl/wr_base_loop.sv
// Write-side frame-buffer pointer manager: picks the next S2MM slot away from
// the reader's slot and publishes only frames with exactly VACTIVE lines.
module wr_base_loop
    import vdma_pkg::*;
#(
    parameter int BUF_NUM = 3,
    parameter int VACTIVE = 1080,
    parameter int LCNT_W  = 12
) (
    input  logic             wclk,
    input  logic             wr_rst,
    input  logic             vsync,
    input  logic             de,
    input  logic [PTR_W-1:0] rd_curr_point,
    output logic [PTR_W-1:0] wr_curr_point,
    output logic [PTR_W-1:0] last_next_point,
    output logic             frame_done,
    output logic             frame_drop
);

    logic              vs_q1, vs_q2;
    logic              de_q1, de_q2;
    logic              vs_rise, de_fall;
    logic [LCNT_W-1:0] lcnt;
    logic [LCNT_W-1:0] lcnt_inc;
    logic [LCNT_W-1:0] lcnt_eval;
    logic              good;
    logic              armed;
    logic [PTR_W-1:0]  rd_sync;
    logic [PTR_W-1:0]  rot1;
    logic [PTR_W-1:0]  nxt;

    ptr_sync #(
        .BUF_NUM(BUF_NUM)
    ) u_ptr_sync (
        .clk(wclk),
        .rst(wr_rst),
        .d  (rd_curr_point),
        .q  (rd_sync)
    );

    assign vs_rise   = vs_q1 & ~vs_q2;
    assign de_fall   = ~de_q1 & de_q2;
    assign lcnt_inc  = (lcnt == '1) ? lcnt : lcnt + 1'b1;
    // A line ending in the same cycle as vsync still belongs to this frame.
    assign lcnt_eval = de_fall ? lcnt_inc : lcnt;
    assign good      = (lcnt_eval == LCNT_W'(VACTIVE));
    assign rot1      = rotl_onehot(wr_curr_point, BUF_NUM);
    assign nxt       = (rot1 == rd_sync) ? rotl_onehot(rot1, BUF_NUM) : rot1;

    always_ff @(posedge wclk or posedge wr_rst) begin
        if (wr_rst) begin
            vs_q1           <= 1'b0;
            vs_q2           <= 1'b0;
            de_q1           <= 1'b0;
            de_q2           <= 1'b0;
            lcnt            <= '0;
            armed           <= 1'b0;
            wr_curr_point   <= WR_PTR_RST;
            last_next_point <= RD_PTR_RST;
            frame_done      <= 1'b0;
            frame_drop      <= 1'b0;
        end else begin
            vs_q1      <= vsync;
            vs_q2      <= vs_q1;
            de_q1      <= de;
            de_q2      <= de_q1;
            frame_done <= 1'b0;
            frame_drop <= 1'b0;

            if (vs_rise)
                lcnt <= '0;
            else if (de_fall)
                lcnt <= lcnt_inc;

            // The first vsync after reset only aligns us to a frame boundary.
            if (vs_rise) begin
                if (!armed) begin
                    armed <= 1'b1;
                end else if (good) begin
                    last_next_point <= wr_curr_point;
                    wr_curr_point   <= nxt;
                    frame_done      <= 1'b1;
                end else begin
                    frame_drop <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_wr_base_loop.sv
// Directed bench for wr_base_loop with BUF_NUM=3 and VACTIVE=4; expected
// pointer values are hand-derived from the rotate-and-skip rule.
module tb_wr_base_loop;

    logic       wclk;
    logic       wr_rst;
    logic       vsync;
    logic       de;
    logic [4:0] rd_curr_point;
    logic [4:0] wr_curr_point;
    logic [4:0] last_next_point;
    logic       frame_done;
    logic       frame_drop;

    int assertCount;
    int failCount;
    int doneCnt;
    int dropCnt;
    int doneIdx;

    wr_base_loop #(
        .BUF_NUM(3),
        .VACTIVE(4),
        .LCNT_W (12)
    ) dut (
        .wclk           (wclk),
        .wr_rst         (wr_rst),
        .vsync          (vsync),
        .de             (de),
        .rd_curr_point  (rd_curr_point),
        .wr_curr_point  (wr_curr_point),
        .last_next_point(last_next_point),
        .frame_done     (frame_done),
        .frame_drop     (frame_drop)
    );

    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h", tag, actual, expected);
        end
    endtask

    task automatic applyLines(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge wclk) de = 1'b1;
            @(negedge wclk) de = 1'b0;
            @(negedge wclk);
        end
    endtask

    // Raise vsync (optionally ending a line in the same cycle) and watch the
    // pulses over the following cycles.
    task automatic applyStimulus(input bit coincident);
        doneCnt = 0;
        dropCnt = 0;
        doneIdx = -1;
        if (coincident) begin
            @(negedge wclk) de = 1'b1;
        end
        @(negedge wclk);
        vsync = 1'b1;
        if (coincident) de = 1'b0;
        for (int i = 0; i < 7; i++) begin
            @(negedge wclk);
            if (frame_done) begin
                doneCnt++;
                if (doneIdx < 0) doneIdx = i;
            end
            if (frame_drop) begin
                dropCnt++;
                if (doneIdx < 0) doneIdx = i;
            end
            if (i == 2) vsync = 1'b0;
        end
    endtask

    initial begin
        assertCount   = 0;
        failCount     = 0;
        wr_rst        = 1'b1;
        vsync         = 1'b0;
        de            = 1'b0;
        rd_curr_point = 5'b00010;

        repeat (3) @(negedge wclk);
        checkOutput("rst_wr", 32'(wr_curr_point), 32'h01);
        checkOutput("rst_last", 32'(last_next_point), 32'h02);
        checkOutput("rst_done", 32'(frame_done), 32'h0);
        checkOutput("rst_drop", 32'(frame_drop), 32'h0);
        @(negedge wclk) wr_rst = 1'b0;
        repeat (6) @(negedge wclk);

        applyStimulus(1'b0);
        checkOutput("first_done", 32'(doneCnt), 32'd0);
        checkOutput("first_drop", 32'(dropCnt), 32'd0);
        checkOutput("first_wr", 32'(wr_curr_point), 32'h01);
        checkOutput("first_last", 32'(last_next_point), 32'h02);

        applyLines(4);
        applyStimulus(1'b0);
        checkOutput("good_done_cnt", 32'(doneCnt), 32'd1);
        checkOutput("good_latency", 32'(doneIdx), 32'd1);
        checkOutput("good_drop", 32'(dropCnt), 32'd0);
        checkOutput("good_last", 32'(last_next_point), 32'h01);
        checkOutput("good_wr_skip", 32'(wr_curr_point), 32'h04);

        applyLines(3);
        applyStimulus(1'b0);
        checkOutput("short_drop", 32'(dropCnt), 32'd1);
        checkOutput("short_done", 32'(doneCnt), 32'd0);
        checkOutput("short_wr", 32'(wr_curr_point), 32'h04);
        checkOutput("short_last", 32'(last_next_point), 32'h01);

        applyLines(3);
        applyStimulus(1'b1);
        checkOutput("coin_done", 32'(doneCnt), 32'd1);
        checkOutput("coin_drop", 32'(dropCnt), 32'd0);
        checkOutput("coin_last", 32'(last_next_point), 32'h04);
        checkOutput("coin_wr_wrap", 32'(wr_curr_point), 32'h01);

        applyLines(4);
        applyStimulus(1'b0);
        checkOutput("good2_last", 32'(last_next_point), 32'h01);
        checkOutput("good2_wr", 32'(wr_curr_point), 32'h04);

        for (int i = 0; i < 10; i++) begin
            @(negedge wclk) rd_curr_point = (i % 2 == 0) ? 5'b00001 : 5'b00100;
        end
        @(negedge wclk);
        checkOutput("cdc_toggle_hold", 32'(dut.rd_sync), 32'h02);
        rd_curr_point = 5'b01000;
        repeat (6) @(negedge wclk);
        checkOutput("cdc_illegal_hold", 32'(dut.rd_sync), 32'h02);
        rd_curr_point = 5'b00001;
        repeat (6) @(negedge wclk);
        checkOutput("cdc_settled", 32'(dut.rd_sync), 32'h01);

        applyLines(4);
        applyStimulus(1'b0);
        checkOutput("cdc_done", 32'(doneCnt), 32'd1);
        checkOutput("cdc_last", 32'(last_next_point), 32'h04);
        checkOutput("cdc_wr_skip", 32'(wr_curr_point), 32'h02);

        applyLines(5);
        applyStimulus(1'b0);
        checkOutput("long_drop", 32'(dropCnt), 32'd1);
        checkOutput("long_wr", 32'(wr_curr_point), 32'h02);
        checkOutput("long_last", 32'(last_next_point), 32'h04);

        applyLines(2);
        @(negedge wclk) de = 1'b1;
        #2 wr_rst = 1'b1;
        #1;
        checkOutput("midrst_wr", 32'(wr_curr_point), 32'h01);
        checkOutput("midrst_last", 32'(last_next_point), 32'h02);
        @(negedge wclk) de = 1'b0;
        @(negedge wclk) wr_rst = 1'b0;
        repeat (6) @(negedge wclk);

        applyLines(4);
        applyStimulus(1'b0);
        checkOutput("rearm_done", 32'(doneCnt), 32'd0);
        checkOutput("rearm_drop", 32'(dropCnt), 32'd0);
        checkOutput("rearm_wr", 32'(wr_curr_point), 32'h01);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
